// File: rtl/mux_16to1.sv
`default_nettype none
// ============================================================================
// Module      : mux_16to1
// Description : 16:1 single-bit multiplexer. The combinational output f is
//               w[s16]. A registered copy f_q/out_valid is provided for
//               pipelined consumers. Define MUX_ONEHOT_SEL_EN to add a
//               registered one-hot copy of the select (sel_onehot).
// Revision    : 1.0 - initial release
// ============================================================================
module mux_16to1 #(
    parameter int   N_IN    = 16,
    parameter int   SEL_W   = 4,
    parameter logic RST_VAL = 1'b0
) (
    input  logic [0:N_IN-1]  w,
    input  logic [SEL_W-1:0] s16,
    output logic             f,
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             f_q,
    output logic             out_valid
`ifdef MUX_ONEHOT_SEL_EN
    ,
    output logic [N_IN-1:0]  sel_onehot
`endif
);

    // Ascending range on w: s16 == 0 picks the literal MSB. A plain indexed
    // select keeps X on the select visible as X on f in simulation.
    assign f = w[s16];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q       <= RST_VAL;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                f_q <= f;
            end
        end
    end

`ifdef MUX_ONEHOT_SEL_EN
    localparam logic [N_IN-1:0] c_onehot_base = N_IN'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_onehot <= '0;
        end else if (in_valid) begin
            sel_onehot <= c_onehot_base << s16;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_16to1.sv
`default_nettype none
// Bench for mux_16to1: directed vectors, a behavioural model, and a
// per-cycle compare process on the falling edge.
module tb_mux_16to1;

    logic [0:15] w;
    logic [3:0]  s16;
    logic        f;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        f_q;
    logic        out_valid;
`ifdef MUX_ONEHOT_SEL_EN
    logic [15:0] sel_onehot;
`endif

    mux_16to1 dut (
        .w         (w),
        .s16       (s16),
        .f         (f),
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .f_q       (f_q),
        .out_valid (out_valid)
`ifdef MUX_ONEHOT_SEL_EN
        ,
        .sel_onehot(sel_onehot)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic done = 1'b0;

    // Model state: numeric view of w (literal MSB is index 0) and the
    // expected registered outputs.
    logic [15:0] cur_w;
    int          cur_s;
    logic        cur_iv;
    logic        exp_fq;
    logic        exp_ov;
    logic [15:0] exp_oh;

    function automatic logic pick(input logic [15:0] val, input int sel);
        return val[15 - sel];
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!done) begin
            chk("f", {15'd0, f}, {15'd0, pick(cur_w, cur_s)});
            chk("f_q", {15'd0, f_q}, {15'd0, exp_fq});
            chk("out_valid", {15'd0, out_valid}, {15'd0, exp_ov});
`ifdef MUX_ONEHOT_SEL_EN
            chk("sel_onehot", sel_onehot, exp_oh);
`endif
        end
    end

    task automatic apply(input logic [15:0] wv, input int sv, input logic iv);
        cur_w = wv; cur_s = sv; cur_iv = iv;
        w = wv; s16 = 4'(sv); in_valid = iv;
    endtask

    // Wait for an edge, advance the model using the inputs that were present
    // at that edge, then drive the next vector and reset level.
    task automatic cyc(input logic [15:0] wv, input int sv, input logic iv, input logic rv);
        @(posedge clk);
        #1;
        if (rst) begin
            exp_fq = 1'b0;
            exp_ov = 1'b0;
            exp_oh = 16'h0000;
        end else begin
            exp_ov = cur_iv;
            if (cur_iv) begin
                exp_fq = pick(cur_w, cur_s);
                exp_oh = 16'h0001 << cur_s;
            end
        end
        rst = rv;
        apply(wv, sv, iv);
    endtask

    initial begin
        exp_fq = 1'b0; exp_ov = 1'b0; exp_oh = 16'h0000;
        rst = 1'b1;
        apply(16'h0000, 0, 1'b0);
        #1;
        chk("reset_f_q", {15'd0, f_q}, 16'd0);
        chk("reset_out_valid", {15'd0, out_valid}, 16'd0);

        cyc(16'b1011111110110001, 12, 1'b0, 1'b0);
        #1 chk("lit_w12", {15'd0, f}, 16'd0);
        cyc(16'b1010110110110001, 13, 1'b1, 1'b0);
        #1 chk("lit_w13", {15'd0, f}, 16'd0);
        cyc(16'b1111110110110001, 3, 1'b1, 1'b0);
        #1 chk("lit_w3", {15'd0, f}, 16'd1);
        #1 chk("lit_fq_after_w13", {15'd0, f_q}, 16'd0);
        cyc(16'b1010101101100111, 15, 1'b1, 1'b0);
        #1 chk("lit_w15", {15'd0, f}, 16'd1);
        #1 chk("lit_fq_after_w3", {15'd0, f_q}, 16'd1);

        // Walk every select code over a pattern with only the end bits set.
        for (int i = 0; i < 16; i++) begin
            cyc(16'b1000000000000001, i, 1'b1, 1'b0);
            #1 chk("sweep", {15'd0, f}, (i == 0 || i == 15) ? 16'd1 : 16'd0);
        end

        // Alternating in_valid with varied data.
        for (int i = 0; i < 8; i++) begin
            cyc(16'hA5C3 ^ 16'(i * 16'h1111), (i * 5) % 16, i[0], 1'b0);
        end

        // Hold: f_q stays put while w changes and in_valid is low.
        cyc(16'hFFFF, 7, 1'b1, 1'b0);
        cyc(16'h0000, 7, 1'b0, 1'b0);
        #1 chk("hold_f_zero", {15'd0, f}, 16'd0);
        cyc(16'h0100, 7, 1'b0, 1'b0);
        #1 chk("hold_f_track", {15'd0, f}, 16'd1);
        cyc(16'h0000, 7, 1'b0, 1'b0);
        #1 chk("hold_f_q", {15'd0, f_q}, 16'd1);
        #1 chk("hold_out_valid", {15'd0, out_valid}, 16'd0);

        // Mid-cycle asynchronous reset with f_q high and a capture in flight.
        cyc(16'hFFFF, 9, 1'b1, 1'b0);
        cyc(16'hFFFF, 9, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        exp_fq = 1'b0; exp_ov = 1'b0; exp_oh = 16'h0000;
        #1;
        chk("async_rst_f_q", {15'd0, f_q}, 16'd0);
        chk("async_rst_out_valid", {15'd0, out_valid}, 16'd0);
        cyc(16'h1000, 3, 1'b1, 1'b1);
        cyc(16'h1000, 3, 1'b1, 1'b0);
        #1 chk("during_rst_f_q", {15'd0, f_q}, 16'd0);
        cyc(16'h0000, 0, 1'b0, 1'b0);
        #1 chk("post_rst_f_q", {15'd0, f_q}, 16'd1);
        #1 chk("post_rst_out_valid", {15'd0, out_valid}, 16'd1);

`ifdef MUX_ONEHOT_SEL_EN
        cyc(16'h0000, 12, 1'b1, 1'b0);
        cyc(16'h0000, 12, 1'b0, 1'b0);
        #1 chk("onehot_12", sel_onehot, 16'h1000);
        #2 rst = 1'b1;
        exp_fq = 1'b0; exp_ov = 1'b0; exp_oh = 16'h0000;
        #1 chk("onehot_rst", sel_onehot, 16'h0000);
        cyc(16'h0000, 0, 1'b0, 1'b0);
`endif

        cyc(16'h0000, 0, 1'b0, 1'b0);
        cyc(16'h0000, 0, 1'b0, 1'b0);
        @(posedge clk);
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
